mem_loader: RTL
===============

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; assertion forces reset state immediately, release takes effect at next Clock edge.
REQ-003 start  input  1  one-cycle load request; sampled only in IDLE.
REQ-004 abort  input  1  cancels an active load; sampled in WRITE and VERIFY.
REQ-005 base_addr  input  8  first RAM address of the image.
REQ-006 length  input  8  byte count; 0 means 256.
REQ-007 in_data  input  8  image byte from the host stream.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Mem_Q  input  8  RAM read data, combinational from Mem_Address.
REQ-011 Mem_Address  output  8  RAM address.
REQ-012 Mem_Data  output  8  RAM write data.
REQ-013 Mem_WR  output  1  1 = write, 0 = read.
REQ-014 Mem_CS  output  1  RAM chip select, active-low.
REQ-015 busy  output  1  load in progress.
REQ-016 cpu_hold  output  1  CPU control unit and sequence counter held off RAM.
REQ-017 done  output  1  one-cycle pulse on completion.
REQ-018 error  output  1  sticky verify-mismatch flag; cleared by next accepted start.
REQ-019 checksum  output  8  mod-256 sum of bytes written by the last load.

Function
REQ-020 FSM states: IDLE, WRITE, VERIFY, DONE; no other states reachable.
REQ-021 IDLE: start=1 -> latch base_addr, latch length (0 -> 256), clear count, checksum and error, go to WRITE; start=0 -> stay.
REQ-022 Byte address = latched base + count, 8-bit, wrap-around mod 256 (base 0xFE, length 4 -> 0xFE, 0xFF, 0x00, 0x01).
REQ-023 WRITE: in_ready=1; Mem_CS=~in_valid, Mem_WR=in_valid, Mem_Data=in_data, Mem_Address=byte address (combinational).
REQ-024 WRITE handshake = in_valid & in_ready at rising edge; RAM commits the byte on the same edge; count+1; checksum += in_data.
REQ-025 in_valid=0 in WRITE: no RAM access, count and checksum unchanged, no timeout.
REQ-026 Handshake on last byte (count = len-1): count cleared, readback sum cleared, go to VERIFY.
REQ-027 VERIFY: in_ready=0, Mem_CS=0, Mem_WR=0, Mem_Address=byte address; each edge adds Mem_Q to readback sum, count+1; one byte per cycle, exactly len cycles.
REQ-028 End of VERIFY: error=1 if final readback sum != checksum; go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, Mem_CS=1, then IDLE.
REQ-030 busy=1 and cpu_hold=1 in WRITE, VERIFY and DONE; 0 in IDLE.
REQ-031 IDLE: in_ready=0, Mem_CS=1, Mem_WR=0, done=0.
REQ-032 start outside IDLE is ignored; base_addr/length changes after latching are ignored.
REQ-033 abort=1 in WRITE or VERIFY -> IDLE at next edge; no done pulse; error unchanged; a handshake in that cycle still writes RAM.
REQ-034 Latency: 256-byte load with in_valid held high = 256 WRITE + 256 VERIFY + 1 DONE = 513 cycles from the edge after start.

Reset
REQ-035 Reset low -> state IDLE, count 0, checksum 0, error 0, done 0, busy 0, cpu_hold 0, in_ready 0, Mem_CS 1, Mem_WR 0, Mem_Address 0, Mem_Data 0.
REQ-036 Reset mid-WRITE or mid-VERIFY: abandon the load immediately, no done, no further RAM access; RAM contents already written are retained.

Verification
REQ-037 base 0x10, length 3, bytes 0xA1,0xB2,0xC3 continuous -> RAM[0x10..0x12] correct, checksum 0x16, done 7 cycles after start edge, error 0.
REQ-038 base 0xFE, length 4, bytes 1,2,3,4 with in_valid gaps -> RAM[0xFE],[0xFF],[0x00],[0x01] = 1..4, no writes during gaps, checksum 0x0A.
REQ-039 length 0, 256 incrementing bytes -> all RAM written, 513-cycle latency, checksum 0x80, error 0.
REQ-040 RAM model forced to corrupt one readback byte -> error 1 with done pulse; next start clears error.
REQ-041 abort after 2 of 5 bytes -> IDLE next cycle, busy 0, no done; start during WRITE ignored.
REQ-042 Reset low during VERIFY -> all outputs at reset values asynchronously; Mem_CS 1 before next edge.

Source files
------------

// File: rtl/mem_loader_if.sv
// Host byte stream plus RAM port between mem_loader and its surroundings.
// Ports: in_data/in_valid/in_ready stream; Mem_Q/Mem_Address/Mem_Data/Mem_WR/Mem_CS RAM.
// slave = loader side (sinks the stream, drives the RAM); master = host/RAM side.
interface mem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Mem_Q;
  logic [7:0] Mem_Address;
  logic [7:0] Mem_Data;
  logic       Mem_WR;
  logic       Mem_CS;

  modport master (
    output in_data, in_valid, Mem_Q,
    input  in_ready, Mem_Address, Mem_Data, Mem_WR, Mem_CS
  );

  modport slave (
    input  in_data, in_valid, Mem_Q,
    output in_ready, Mem_Address, Mem_Data, Mem_WR, Mem_CS
  );
endinterface

// File: rtl/mem_loader.sv
// Loads a host byte image into RAM at base_addr, then reads it back and compares sums.
// Latency: len WRITE cycles (one per accepted byte) + len VERIFY cycles + 1 DONE cycle.
// Backpressure: in_ready high only in WRITE; in_valid gaps simply stall the load.
// Ports: clk, Reset (async active-low), start/abort/base_addr/length control,
//        bus (stream + RAM), busy/cpu_hold/done/error/checksum status.
module mem_loader (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  base_addr,
  input  logic [7:0]  length,
  mem_loader_if.slave bus,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] base_q;
  logic [7:0] len_m1_q;   // length-1; length 0 wraps to 255, i.e. 256 bytes
  logic [7:0] count_q;
  logic [7:0] rsum_q;
  logic [7:0] checksum_q;
  logic       error_q;

  logic [7:0] byte_addr;
  logic [7:0] rsum_nxt;
  logic       last;
  logic       hs;

  assign byte_addr = base_q + count_q;
  assign rsum_nxt  = rsum_q + bus.Mem_Q;
  assign last      = (count_q == len_m1_q);
  assign hs        = (state == WRITE) && bus.in_valid;

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (abort) state_nxt = IDLE;
               else if (hs && last) state_nxt = VERIFY;
      VERIFY:  if (abort) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.Mem_WR      = 1'b0;
    bus.Mem_Address = 8'h00;
    bus.Mem_Data    = 8'h00;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      WRITE: begin
        bus.in_ready    = 1'b1;
        bus.Mem_CS      = ~bus.in_valid;
        bus.Mem_WR      = bus.in_valid;
        bus.Mem_Data    = bus.in_data;
        bus.Mem_Address = byte_addr;
        busy            = 1'b1;
      end
      VERIFY: begin
        bus.Mem_CS      = 1'b0;
        bus.Mem_Address = byte_addr;
        busy            = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_hold = busy;
  assign error    = error_q;
  assign checksum = checksum_q;

  // Datapath: latched load parameters, byte counter and the two sums
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      base_q     <= 8'h00;
      len_m1_q   <= 8'h00;
      count_q    <= 8'h00;
      rsum_q     <= 8'h00;
      checksum_q <= 8'h00;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q     <= base_addr;
          len_m1_q   <= length - 8'd1;
          count_q    <= 8'h00;
          rsum_q     <= 8'h00;
          checksum_q <= 8'h00;
          error_q    <= 1'b0;
        end
        WRITE: if (hs) begin
          // The RAM commits this byte on the same edge even if abort is high,
          // so the checksum keeps covering everything actually written.
          checksum_q <= checksum_q + bus.in_data;
          if (last) begin
            count_q <= 8'h00;
            rsum_q  <= 8'h00;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        VERIFY: begin
          rsum_q  <= rsum_nxt;
          count_q <= count_q + 8'd1;
          if (last && !abort && (rsum_nxt != checksum_q)) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
